axis_reg_fifo: RTL and testbench



---
 rtl/axis_reg_fifo.sv | 171 +++++++++++++++++
 tb/tb_axis_reg_fifo.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_reg_fifo.sv
// -----------------------------------------------------------------------------
// axis_reg_fifo
//
// Parametrised AXI-Stream register FIFO. It decouples an upstream producer from
// a downstream consumer by up to DEPTH beats and sustains one beat per cycle.
// Every output is decoded from registered state only, so there is no
// combinational path from any input to any output. An empty FIFO does not
// fall through: a beat pushed at one edge reaches the output after that edge.
//
// Optional feature macro: AXIS_REG_FIFO_TLAST_EN
//   defined   -> tlast_i / tlast_o ports exist and a tlast bit per entry
//                travels with its data beat.
//   undefined -> no tlast ports and no tlast storage.
//
// Parameters:
//   DATA_W  payload width in bits (>= 1)
//   DEPTH   number of storage entries (power of two, >= 2)
//
// Ports:
//   clk_i     clock, all state changes on its rising edge
//   rst_i     synchronous active-high reset
//   tvalid_i  upstream beat valid
//   tready_o  FIFO can accept a beat (low while in reset and when full)
//   tdata_i   upstream payload
//   tlast_i   upstream end-of-packet        (AXIS_REG_FIFO_TLAST_EN only)
//   tlast_o   head-entry end-of-packet      (AXIS_REG_FIFO_TLAST_EN only)
//   tvalid_o  downstream beat valid (FIFO not empty)
//   tready_i  downstream ready
//   tdata_o   downstream payload, head of FIFO
//   level_o   number of stored beats, 0..DEPTH
// -----------------------------------------------------------------------------
module axis_reg_fifo #(
   parameter int DATA_W = 4,
   parameter int DEPTH  = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       tvalid_i,
   output logic                       tready_o,
   input  logic [DATA_W-1:0]          tdata_i,
`ifdef AXIS_REG_FIFO_TLAST_EN
   input  logic                       tlast_i,
   output logic                       tlast_o,
`endif
   output logic                       tvalid_o,
   input  logic                       tready_i,
   output logic [DATA_W-1:0]          tdata_o,
   output logic [$clog2(DEPTH+1)-1:0] level_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];

`ifdef AXIS_REG_FIFO_TLAST_EN
   logic              last_q [DEPTH];
   logic              last_d [DEPTH];
`else
   // No end-of-packet sideband: only the payload is stored per entry.
`endif

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q,  count_d;

   // Registered acceptance flag. Holding it in a flop (rather than decoding
   // count and rst_i directly) keeps tready_o low during reset cycles without
   // creating a path from rst_i to tready_o, and makes a pop from a full FIFO
   // raise tready_o only in the following cycle.
   logic              ready_q,  ready_d;

   // ---------------------------------------------------------------------------
   // Transfer events
   // ---------------------------------------------------------------------------
   logic              valid;
   logic              push;
   logic              pop;

   assign valid = (count_q != '0);
   assign push  = tvalid_i & ready_q;
   assign pop   = valid & tready_i;

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal driven in this block is given a default first, so no
      // path through the block leaves it unassigned and no latch is inferred.
      mem_d    = mem_q;
`ifdef AXIS_REG_FIFO_TLAST_EN
      last_d   = last_q;
`endif
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (push) begin
         mem_d[wr_ptr_q]  = tdata_i;
`ifdef AXIS_REG_FIFO_TLAST_EN
         last_d[wr_ptr_q] = tlast_i;
`endif
         // DEPTH is a power of two, so the pointer wraps on its own.
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end

      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end

      unique case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      ready_d = (count_d != CNT_FULL);
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples the values from before this edge, independent of statement order.
      if (rst_i) begin
         // NOTE: the storage array is reset as well, because the head entry is
         // always visible on tdata_o/tlast_o and must read as zero after reset
         // even though the FIFO is empty.
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i]  <= '0;
`ifdef AXIS_REG_FIFO_TLAST_EN
            last_q[i] <= 1'b0;
`endif
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ready_q  <= 1'b0;
      end else begin
         mem_q    <= mem_d;
`ifdef AXIS_REG_FIFO_TLAST_EN
         last_q   <= last_d;
`endif
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ready_q  <= ready_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs (registered state only)
   // ---------------------------------------------------------------------------
   assign tready_o = ready_q;
   assign tvalid_o = valid;
   assign tdata_o  = mem_q[rd_ptr_q];
`ifdef AXIS_REG_FIFO_TLAST_EN
   assign tlast_o  = last_q[rd_ptr_q];
`endif
   assign level_o  = count_q;

endmodule

// File: tb/tb_axis_reg_fifo.sv
// -----------------------------------------------------------------------------
// tb_axis_reg_fifo
//
// Self-checking bench for axis_reg_fifo with DATA_W=4, DEPTH=4. Directed
// table vectors and hand-written sequences cover reset, fill, full/pop
// interaction, streaming, tlast and mid-operation reset; a randomized phase is
// compared against a queue-based reference model of the FIFO's behaviour.
// tlast checks are active when AXIS_REG_FIFO_TLAST_EN is defined.
// -----------------------------------------------------------------------------
module tb_axis_reg_fifo;

   localparam int DATA_W = 4;
   localparam int DEPTH  = 4;
   localparam int LVL_W  = $clog2(DEPTH + 1);

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic              tvalid_i;
   logic              tready_o;
   logic [DATA_W-1:0] tdata_i;
   logic              tvalid_o;
   logic              tready_i;
   logic [DATA_W-1:0] tdata_o;
   logic [LVL_W-1:0]  level_o;
   logic              in_last;

`ifdef AXIS_REG_FIFO_TLAST_EN
   logic              tlast_i;
   logic              tlast_o;
   assign tlast_i = in_last;
`endif

   always #5 clk_i = ~clk_i;

   axis_reg_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .tvalid_i (tvalid_i),
      .tready_o (tready_o),
      .tdata_i  (tdata_i),
`ifdef AXIS_REG_FIFO_TLAST_EN
      .tlast_i  (tlast_i),
      .tlast_o  (tlast_o),
`endif
      .tvalid_o (tvalid_o),
      .tready_i (tready_i),
      .tdata_o  (tdata_o),
      .level_o  (level_o)
   );

   // ---------------------------------------------------------------------------
   // Bookkeeping
   // ---------------------------------------------------------------------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: an ordered queue of beats plus a "reset seen at the last
   // edge" flag. Acceptance and presentation follow the FIFO rules directly.
   // ---------------------------------------------------------------------------
   typedef struct packed {
      logic              last;
      logic [DATA_W-1:0] data;
   } beat_t;

   beat_t m_q[$];
   bit    m_rst = 1'b1;

   function automatic bit m_ready();
      return !m_rst && (m_q.size() < DEPTH);
   endfunction

   task automatic model_edge();
      bit    do_push;
      bit    do_pop;
      beat_t b;
      if (rst_i) begin
         m_q.delete();
         m_rst = 1'b1;
      end else begin
         do_push = tvalid_i && m_ready();
         do_pop  = (m_q.size() != 0) && tready_i;
         if (do_pop) void'(m_q.pop_front());
         if (do_push) begin
            b.last = in_last;
            b.data = tdata_i;
            m_q.push_back(b);
         end
         m_rst = 1'b0;
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, "_ready"}, 32'(tready_o), 32'(m_ready()));
      check({tag, "_valid"}, 32'(tvalid_o), 32'(m_q.size() != 0));
      check({tag, "_level"}, 32'(level_o),  32'(m_q.size()));
      if (m_q.size() != 0) begin
         check({tag, "_data"}, 32'(tdata_o), 32'(m_q[0].data));
`ifdef AXIS_REG_FIFO_TLAST_EN
         check({tag, "_last"}, 32'(tlast_o), 32'(m_q[0].last));
`endif
      end
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------------------
   task automatic drive(input logic rst, input logic vi, input logic [DATA_W-1:0] d,
                        input logic l, input logic ri);
      rst_i    = rst;
      tvalid_i = vi;
      tdata_i  = d;
      in_last  = l;
      tready_i = ri;
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk_i);
      model_edge();
      #1;
   endtask

   // ---------------------------------------------------------------------------
   // Directed vector table
   // ---------------------------------------------------------------------------
   typedef struct {
      logic              rst;
      logic              vi;
      logic [DATA_W-1:0] d;
      logic              ri;
      logic              e_rdy;
      logic              e_vld;
      logic              chk_data;
      logic [DATA_W-1:0] e_data;
      logic [LVL_W-1:0]  e_lvl;
   } vec_t;

   function automatic vec_t mk(input logic rst, input logic vi, input logic [DATA_W-1:0] d,
                               input logic ri, input logic e_rdy, input logic e_vld,
                               input logic chk_data, input logic [DATA_W-1:0] e_data,
                               input logic [LVL_W-1:0] e_lvl);
      vec_t v;
      v.rst = rst; v.vi = vi; v.d = d; v.ri = ri;
      v.e_rdy = e_rdy; v.e_vld = e_vld; v.chk_data = chk_data;
      v.e_data = e_data; v.e_lvl = e_lvl;
      return v;
   endfunction

   vec_t vecs[$];

   logic [DATA_W-1:0] stream_d [5];
   logic [DATA_W-1:0] pkt_d    [4];
   logic              pkt_l    [4];

   initial begin
      //               rst vi  d     ri   rdy  vld  chkd data  lvl
      vecs.push_back(mk(1, 0, 4'h0, 0,   0,   0,   1,   4'h0, 0)); // reset
      vecs.push_back(mk(1, 1, 4'h6, 1,   0,   0,   1,   4'h0, 0)); // push/pop ignored in reset
      vecs.push_back(mk(0, 0, 4'h0, 0,   1,   0,   1,   4'h0, 0)); // idle after reset
      vecs.push_back(mk(0, 1, 4'h1, 0,   1,   1,   1,   4'h1, 1)); // fill
      vecs.push_back(mk(0, 1, 4'h8, 0,   1,   1,   1,   4'h1, 2));
      vecs.push_back(mk(0, 1, 4'h2, 0,   1,   1,   1,   4'h1, 3));
      vecs.push_back(mk(0, 1, 4'hC, 0,   0,   1,   1,   4'h1, 4)); // full
      vecs.push_back(mk(0, 1, 4'hD, 0,   0,   1,   1,   4'h1, 4)); // 5th beat refused
      vecs.push_back(mk(0, 1, 4'hD, 1,   1,   1,   1,   4'h8, 3)); // pop from full, no push
      vecs.push_back(mk(0, 1, 4'hD, 0,   0,   1,   1,   4'h8, 4)); // D pushed next cycle
      vecs.push_back(mk(0, 0, 4'h0, 1,   1,   1,   1,   4'h2, 3)); // drain
      vecs.push_back(mk(0, 0, 4'h0, 1,   1,   1,   1,   4'hC, 2));
      vecs.push_back(mk(0, 0, 4'h0, 1,   1,   1,   1,   4'hD, 1));
      vecs.push_back(mk(0, 0, 4'h0, 1,   1,   0,   0,   4'h0, 0)); // empty
      vecs.push_back(mk(0, 0, 4'h0, 1,   1,   0,   0,   4'h0, 0)); // tready_i ignored
      vecs.push_back(mk(0, 1, 4'h5, 1,   1,   1,   1,   4'h5, 1)); // no fall-through
      vecs.push_back(mk(0, 0, 4'h0, 1,   1,   0,   0,   4'h0, 0));

      stream_d = '{4'h3, 4'h9, 4'h3, 4'hE, 4'h8};
      pkt_d    = '{4'h6, 4'h4, 4'h7, 4'h2};
      pkt_l    = '{1'b0, 1'b0, 1'b1, 1'b0};

      drive(1, 0, 4'h0, 0, 0);

      // ---- table ---------------------------------------------------------
      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].vi, vecs[i].d, 1'b0, vecs[i].ri);
         tick();
         check($sformatf("vec%0d_ready", i), 32'(tready_o), 32'(vecs[i].e_rdy));
         check($sformatf("vec%0d_valid", i), 32'(tvalid_o), 32'(vecs[i].e_vld));
         check($sformatf("vec%0d_level", i), 32'(level_o),  32'(vecs[i].e_lvl));
         if (vecs[i].chk_data)
            check($sformatf("vec%0d_data", i), 32'(tdata_o), 32'(vecs[i].e_data));
      end

      // ---- continuous streaming ------------------------------------------
      for (int k = 0; k < 5; k++) begin
         drive(0, 1, stream_d[k], 0, 1);
         tick();
         check($sformatf("stream%0d_data", k),  32'(tdata_o),  32'(stream_d[k]));
         check($sformatf("stream%0d_valid", k), 32'(tvalid_o), 32'd1);
         check($sformatf("stream%0d_level", k), 32'(level_o),  32'd1);
         check($sformatf("stream%0d_ready", k), 32'(tready_o), 32'd1);
      end
      drive(0, 0, 4'h0, 0, 1);
      tick();
      check("stream_drain_level", 32'(level_o), 32'd0);

      // ---- packet with tlast on 3rd beat ---------------------------------
      for (int k = 0; k < 4; k++) begin
         drive(0, 1, pkt_d[k], pkt_l[k], 0);
         tick();
         check($sformatf("pkt_fill%0d_data", k), 32'(tdata_o), 32'(pkt_d[0]));
`ifdef AXIS_REG_FIFO_TLAST_EN
         check($sformatf("pkt_fill%0d_last", k), 32'(tlast_o), 32'(pkt_l[0]));
`endif
      end
      for (int k = 1; k < 4; k++) begin
         drive(0, 0, 4'h0, 0, 1);
         tick();
         check($sformatf("pkt_head%0d_data", k), 32'(tdata_o), 32'(pkt_d[k]));
`ifdef AXIS_REG_FIFO_TLAST_EN
         check($sformatf("pkt_head%0d_last", k), 32'(tlast_o), 32'(pkt_l[k]));
`endif
      end
      drive(0, 0, 4'h0, 0, 1);
      tick();
      check("pkt_empty_valid", 32'(tvalid_o), 32'd0);

      // ---- reset mid-operation -------------------------------------------
      drive(0, 1, 4'hA, 0, 0); tick();
      drive(0, 1, 4'hB, 1, 0); tick();
      drive(0, 1, 4'hC, 0, 0); tick();
      check("midrst_pre_level", 32'(level_o), 32'd3);
      drive(1, 1, 4'hF, 1, 1); tick();
      check("midrst_level", 32'(level_o),  32'd0);
      check("midrst_valid", 32'(tvalid_o), 32'd0);
      check("midrst_data",  32'(tdata_o),  32'd0);
      check("midrst_ready", 32'(tready_o), 32'd0);
`ifdef AXIS_REG_FIFO_TLAST_EN
      check("midrst_last",  32'(tlast_o),  32'd0);
`endif
      drive(0, 0, 4'h0, 0, 0); tick();
      check("postrst_ready", 32'(tready_o), 32'd1);
      drive(0, 1, 4'h5, 0, 0); tick();
      check("postrst_head",  32'(tdata_o),  32'h5);
      check("postrst_level", 32'(level_o),  32'd1);
      drive(0, 0, 4'h0, 0, 1); tick();
      check("postrst_drain", 32'(level_o),  32'd0);

      // ---- randomized phase against the reference model ------------------
      for (int c = 0; c < 3000; c++) begin
         logic r_rst, r_vi, r_ri;
         r_rst = ($urandom_range(99) == 0);
         r_vi  = ($urandom_range(3) != 0);
         // Alternate phases biased toward filling and toward draining.
         if (((c / 200) % 2) == 0) r_ri = ($urandom_range(3) == 0);
         else                      r_ri = ($urandom_range(3) != 0);
         drive(r_rst, r_vi, DATA_W'($urandom_range(15)), 1'($urandom_range(1)), r_ri);
         tick();
         check_model("rnd");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
